// File: rtl/ff_pkg.sv
// Shared FIFO pointer type and full/empty helpers. Pointers carry one wrap
// bit above the address bits. Helpers take the address width as an argument
// so that sync and future async FIFO variants of any depth can share them.
package ff_pkg;

    localparam int FF_PTR_MAX_W = 16;

    // Widest supported pointer; narrower pointers are zero-extended into it.
    typedef logic [FF_PTR_MAX_W-1:0] ff_ptr_t;

    // Full: address bits equal, wrap bits differ.
    function automatic logic ff_is_full(input ff_ptr_t wptr, input ff_ptr_t rptr,
                                        input int addr_w);
        ff_ptr_t mask;
        ff_ptr_t wrap;
        mask = ff_ptr_t'((32'd2 << addr_w) - 32'd1);
        wrap = ff_ptr_t'(32'd1 << addr_w);
        return ((wptr ^ rptr) & mask) == wrap;
    endfunction

    // Empty: pointers identical including the wrap bit.
    function automatic logic ff_is_empty(input ff_ptr_t wptr, input ff_ptr_t rptr,
                                         input int addr_w);
        ff_ptr_t mask;
        mask = ff_ptr_t'((32'd2 << addr_w) - 32'd1);
        return ((wptr ^ rptr) & mask) == '0;
    endfunction

endpackage

// File: rtl/ff_sync_fifo_ram.sv
// Simple dual-port RAM: one write and one registered read per clock.
// The array itself is not reset so it can map onto block RAM; only the
// read-data register is reset, and it holds its value when no read occurs.
module ff_dp_ram
    import ff_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Next read data: fetch on read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Read-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ff_sync_fifo.sv
// Single-clock FIFO with occupancy, watermarks, overflow/underflow pulses and
// synchronous flush. Flags and occupancy are decoded from the registered
// pointers, so they move on the same edge as the pointers.
module ff_sync_fifo
    import ff_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    input  logic              ff_flush,
    input  logic              ff_wr_en,
    input  logic [DATA_W-1:0] ff_wr_data,
    input  logic              ff_rd_en,
    output logic [DATA_W-1:0] ff_rd_data,
    output logic              ff_full,
    output logic              ff_empty,
    output logic              ff_afull,
    output logic              ff_aempty,
    output logic [ADDR_W:0]   ff_occ,
    output logic              ff_ovrflw,
    output logic              ff_undrflw
);

    localparam logic [ADDR_W:0] AFULL_V  = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] AEMPTY_V = (ADDR_W+1)'(AEMPTY_LVL);

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic            ovrflw_q, ovrflw_d;
    logic            undrflw_q, undrflw_d;
    logic            wr_acc;
    logic            rd_acc;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] occ;

    // Status decode from the registered pointers.
    always_comb begin
        full      = ff_is_full(ff_ptr_t'(wptr_q), ff_ptr_t'(rptr_q), ADDR_W);
        empty     = ff_is_empty(ff_ptr_t'(wptr_q), ff_ptr_t'(rptr_q), ADDR_W);
        occ       = wptr_q - rptr_q;
        ff_full   = full;
        ff_empty  = empty;
        ff_occ    = occ;
        ff_afull  = (occ >= AFULL_V);
        ff_aempty = (occ <= AEMPTY_V);
    end

    // Accept/reject decisions and next pointer state; flush overrides both ports.
    always_comb begin
        wr_acc    = !ff_flush && ff_wr_en && !full;
        rd_acc    = !ff_flush && ff_rd_en && !empty;
        ovrflw_d  = !ff_flush && ff_wr_en && full;
        undrflw_d = !ff_flush && ff_rd_en && empty;
        wptr_d    = wptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rptr_d    = rptr_q + {{ADDR_W{1'b0}}, rd_acc};
        if (ff_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    // Pointer and error-pulse registers.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ovrflw_q  <= 1'b0;
            undrflw_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ovrflw_q  <= ovrflw_d;
            undrflw_q <= undrflw_d;
        end
    end

    assign ff_ovrflw  = ovrflw_q;
    assign ff_undrflw = undrflw_q;

    ff_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_ir),
        .rst   (rst_ih),
        .we    (wr_acc),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (ff_wr_data),
        .re    (rd_acc),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (ff_rd_data)
    );

endmodule
